split_target: RTL and testbench
===============================

SPLIT_TARGET -- requirements
Module: split_target

Interface
REQ-001 SHALL have parameters: BASE_ADDR 16'h0010 (first decoded address); MEM_DEPTH 16 (byte locations, power of two, 2..256); MEM_INIT_DATA 8'hA0 (reset seed); READ_LATENCY 2 (cycles, 1..15); SPLIT_EN 1'b0 (1 = reads answered by split transaction).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- target_addr_in  in  16  bus address.
- target_addr_in_valid  in  1  address strobe.
- target_rw  in  1  1=write, 0=read; sampled with the address.
- target_data_in  in  8  write data.
- target_data_in_valid  in  1  write-data strobe.
- target_split_grant  in  1  bus grant for split resume.
- target_ready  out  1  1 only in IDLE.
- target_ack  out  1  one-cycle completion pulse.
- target_split_ack  out  1  one-cycle split pulse.
- target_split_req  out  1  resume request.
- target_data_out  out  8  read data.
- target_data_out_valid  out  1  read-data strobe.

Function
REQ-004 SHALL decode an address as in range iff BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH; offset = (addr-BASE_ADDR) truncated to log2(MEM_DEPTH) bits.
REQ-005 SHALL implement states IDLE, WR_COLLECT, WR_ACK, RD_WAIT, RD_SPLIT_WAIT, RD_RESUME, RD_RESP.
REQ-006 SHALL, in IDLE, latch target_data_in on target_data_in_valid and set a data_pending flag; a later strobe overwrites the latched byte.
REQ-007 SHALL, in IDLE, capture an in-range address with rw=1: go to WR_ACK if data_pending or data valid in the same cycle (same-cycle data wins), else WR_COLLECT.
REQ-008 SHALL, in WR_COLLECT, go to WR_ACK on the first target_data_in_valid, capturing that byte.
REQ-009 SHALL, on entering WR_ACK, write mem[offset] at that edge and assert target_ack exactly one cycle, then return to IDLE and clear data_pending.
REQ-010 SHALL, in IDLE, on an in-range address with rw=0 clear data_pending and go to RD_WAIT with a latency counter loaded to READ_LATENCY.
REQ-011 SHALL, with SPLIT_EN=0, assert target_data_out_valid and target_ack together for one cycle, starting READ_LATENCY edges after the capture edge, target_data_out = mem[offset]; then IDLE.
REQ-012 SHALL, with SPLIT_EN=1, pulse target_split_ack for the one cycle after the capture edge, count READ_LATENCY cycles in RD_SPLIT_WAIT, then enter RD_RESUME and hold target_split_req high.
REQ-013 SHALL, in RD_RESUME, on the edge sampling target_split_grant=1, drop target_split_req and enter RD_RESP; RD_RESP drives target_data_out_valid and target_ack for one cycle, then IDLE.
REQ-014 SHALL ignore out-of-range addresses: no ack, stay IDLE, clear data_pending.
REQ-015 SHALL ignore address strobes outside IDLE, and data strobes outside IDLE/WR_COLLECT.
REQ-016 SHALL hold target_data_out at the last read value between responses.
REQ-017 SHALL drive target_ready = 1 only in IDLE.
REQ-018 SHALL complete a read of an address written earlier with the new value; memory is not bypassed within a single cycle.

Reset
REQ-019 SHALL, on rst=1 at any time including mid-transaction, asynchronously force IDLE, clear data_pending and the counter, set target_ready=1, and drive all other outputs to 0.
REQ-020 SHALL reset memory to mem[i] = MEM_INIT_DATA + i (8-bit wrap).

Verification (defaults, except SPLIT_EN where stated)
REQ-021 Write 0x0012 with data 0x5C in the same cycle -> target_ack high for one cycle after the edge. Then read 0x0012 -> data_out 0x5C with valid+ack, 2 edges after capture.
REQ-022 After reset, read 0x0013 -> data_out 0xA3, one-cycle valid+ack; target_ready low from capture until the response completes.
REQ-023 Data 0x77 strobed in IDLE, write address 0x0011 three cycles later -> single ack. Then read 0x0011 -> 0x77.
REQ-024 Read address 0x0034 (out of range) -> no ack, target_ready stays 1, no valid.
REQ-025 SPLIT_EN=1, read 0x0015 -> split_ack for one cycle, split_req after 2 cycles; grant delayed 4 cycles -> split_req held, then data 0xA5 with valid+ack for one cycle after the grant edge.
REQ-026 SPLIT_EN=1, rst pulsed while in RD_RESUME -> split_req 0 immediately, ready 1, no ack afterward.

Source files
------------

// File: rtl/split_target_if.sv
// Bus-side signal bundle for split_target.
// The slave modport is the target view; master is the initiator view.
interface split_target_if;
    logic [15:0] target_addr_in;
    logic        target_addr_in_valid;
    logic        target_rw;
    logic [7:0]  target_data_in;
    logic        target_data_in_valid;
    logic        target_split_grant;
    logic        target_ready;
    logic        target_ack;
    logic        target_split_ack;
    logic        target_split_req;
    logic [7:0]  target_data_out;
    logic        target_data_out_valid;

    modport slave (
        input  target_addr_in, target_addr_in_valid, target_rw,
        input  target_data_in, target_data_in_valid, target_split_grant,
        output target_ready, target_ack, target_split_ack,
        output target_split_req, target_data_out, target_data_out_valid
    );

    modport master (
        output target_addr_in, target_addr_in_valid, target_rw,
        output target_data_in, target_data_in_valid, target_split_grant,
        input  target_ready, target_ack, target_split_ack,
        input  target_split_req, target_data_out, target_data_out_valid
    );
endinterface

// File: rtl/split_target.sv
// Byte-memory bus target with decoupled write data and
// optional split-transaction reads.
module split_target #(
    parameter logic [15:0] BASE_ADDR     = 16'h0010,
    parameter int          MEM_DEPTH     = 16,
    parameter logic [7:0]  MEM_INIT_DATA = 8'hA0,
    parameter int          READ_LATENCY  = 2,
    parameter bit          SPLIT_EN      = 1'b0
) (
    input logic         clk,
    input logic         rst,
    split_target_if.slave bus
);
    localparam int OW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_ACK, RD_WAIT,
        RD_SPLIT_WAIT, RD_RESUME, RD_RESP
    } state_t;

    state_t state, nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [OW-1:0] off_q, addr_off, wr_off;
    logic [7:0]    wdata_q, wr_data, dout_q;
    logic          pending, in_range, wr_en, rd_load, cap;
    logic [7:0]    mem [MEM_DEPTH];
    logic [16:0]   addr17, lo17, hi17;

    assign addr17   = {1'b0, bus.target_addr_in};
    assign lo17     = {1'b0, BASE_ADDR};
    assign hi17     = lo17 + 17'(MEM_DEPTH);
    assign in_range = (addr17 >= lo17) && (addr17 < hi17);
    assign addr_off = OW'(bus.target_addr_in - BASE_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_off  = off_q;
        wr_data = wdata_q;
        rd_load = 1'b0;
        cap     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.target_addr_in_valid && in_range) begin
                    cap = 1'b1;
                    if (bus.target_rw) begin
                        if (bus.target_data_in_valid || pending) begin
                            nxt     = WR_ACK;
                            wr_en   = 1'b1;
                            wr_off  = addr_off;
                            // same-cycle data beats the latched byte
                            wr_data = bus.target_data_in_valid ?
                                      bus.target_data_in : wdata_q;
                        end else begin
                            nxt = WR_COLLECT;
                        end
                    end else begin
                        nxt     = SPLIT_EN ? RD_SPLIT_WAIT : RD_WAIT;
                        cnt_nxt = 4'(READ_LATENCY);
                    end
                end
            end
            WR_COLLECT: begin
                if (bus.target_data_in_valid) begin
                    nxt     = WR_ACK;
                    wr_en   = 1'b1;
                    wr_data = bus.target_data_in;
                end
            end
            WR_ACK: nxt = IDLE;
            RD_WAIT: begin
                if (cnt <= 4'd1) begin
                    nxt     = RD_RESP;
                    cnt_nxt = '0;
                    rd_load = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RD_SPLIT_WAIT: begin
                if (cnt <= 4'd1) begin
                    nxt     = RD_RESUME;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RD_RESUME: begin
                if (bus.target_split_grant) begin
                    nxt     = RD_RESP;
                    rd_load = 1'b1;
                end
            end
            RD_RESP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // any address strobe seen in IDLE consumes or discards pending data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            wdata_q <= '0;
            off_q   <= '0;
            dout_q  <= '0;
        end else begin
            if (state == IDLE) begin
                if (bus.target_addr_in_valid) begin
                    pending <= 1'b0;
                end else if (bus.target_data_in_valid) begin
                    pending <= 1'b1;
                    wdata_q <= bus.target_data_in;
                end
            end
            if (cap)     off_q  <= addr_off;
            if (rd_load) dout_q <= mem[off_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= MEM_INIT_DATA + 8'(i);
        end else if (wr_en) begin
            mem[wr_off] <= wr_data;
        end
    end

    assign bus.target_ready          = (state == IDLE);
    assign bus.target_ack            = (state == WR_ACK) || (state == RD_RESP);
    assign bus.target_data_out_valid = (state == RD_RESP);
    assign bus.target_split_req      = (state == RD_RESUME);
    assign bus.target_split_ack      = (state == RD_SPLIT_WAIT) &&
                                       (cnt == 4'(READ_LATENCY));
    assign bus.target_data_out       = dout_q;
endmodule

// File: tb/tb_split_target.sv
// Scoreboard bench for split_target: one normal and one
// split-mode instance share clock and reset.
module tb_split_target;
    localparam int LAT = 2;

    typedef struct {
        bit         rd;
        logic [7:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t sbq [2][$];
    int   spq [$];

    split_target_if bus0();
    split_target_if bus1();

    split_target #(.SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    split_target #(.SPLIT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] mon_ack, mon_val;
    logic [7:0] mon_dout [2];
    assign mon_ack[0]  = bus0.target_ack;
    assign mon_ack[1]  = bus1.target_ack;
    assign mon_val[0]  = bus0.target_data_out_valid;
    assign mon_val[1]  = bus1.target_data_out_valid;
    assign mon_dout[0] = bus0.target_data_out;
    assign mon_dout[1] = bus1.target_data_out;

    // monitor: pops expectations whenever a DUT responds
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (mon_ack[d]) begin
                    total++;
                    if (sbq[d].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ack dut%0d cyc=%0d", d, cyc);
                    end else begin
                        exp_t e;
                        e = sbq[d].pop_front();
                        if (cyc != e.c || mon_val[d] !== e.rd ||
                            (e.rd && mon_dout[d] !== e.d)) begin
                            bad++;
                            $display("FAIL ack_dut%0d got cyc=%0d valid=%b data=%h want cyc=%0d valid=%b data=%h",
                                     d, cyc, mon_val[d], mon_dout[d], e.c, e.rd, e.d);
                        end
                    end
                end else if (mon_val[d]) begin
                    total++;
                    bad++;
                    $display("FAIL valid_without_ack dut%0d cyc=%0d", d, cyc);
                end
            end
            if (bus0.target_split_ack) begin
                total++;
                bad++;
                $display("FAIL split_ack_dut0 got=1 want=0 cyc=%0d", cyc);
            end
            if (bus1.target_split_ack) begin
                total++;
                if (spq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_split_ack cyc=%0d", cyc);
                end else begin
                    int c;
                    c = spq.pop_front();
                    if (c != cyc) begin
                        bad++;
                        $display("FAIL split_ack_cycle got=%0d want=%0d", cyc, c);
                    end
                end
            end
        end
    end

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int d, logic av, logic [15:0] a, logic rw,
                       logic dv, logic [7:0] dat);
        if (d == 0) begin
            bus0.target_addr_in       = a;
            bus0.target_addr_in_valid = av;
            bus0.target_rw            = rw;
            bus0.target_data_in_valid = dv;
            bus0.target_data_in       = dat;
        end else begin
            bus1.target_addr_in       = a;
            bus1.target_addr_in_valid = av;
            bus1.target_rw            = rw;
            bus1.target_data_in_valid = dv;
            bus1.target_data_in       = dat;
        end
    endtask

    task automatic idle(int d);
        drv(d, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic rd(int d, logic [15:0] a, bit hit, logic [7:0] e);
        drv(d, 1'b1, a, 1'b0, 1'b0, 8'h0);
        if (hit) sbq[d].push_back('{rd: 1'b1, d: e, c: cyc + 1 + LAT});
        tick();
        idle(d);
    endtask

    task automatic wr(int d, logic [15:0] a, logic [7:0] dat);
        drv(d, 1'b1, a, 1'b1, 1'b1, dat);
        sbq[d].push_back('{rd: 1'b0, d: 8'h0, c: cyc + 1});
        tick();
        idle(d);
    endtask

    initial begin
        logic [15:0] oor [3];
        oor[0] = 16'h0034;
        oor[1] = 16'h000F;
        oor[2] = 16'h0020;
        rst = 1'b1;
        idle(0);
        idle(1);
        bus0.target_split_grant = 1'b0;
        bus1.target_split_grant = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready0", 16'(bus0.target_ready), 16'h1);
        chk("rst_ack0", 16'(bus0.target_ack), 16'h0);
        chk("rst_dout0", 16'(bus0.target_data_out), 16'h0);
        chk("rst_valid0", 16'(bus0.target_data_out_valid), 16'h0);
        chk("rst_ready1", 16'(bus1.target_ready), 16'h1);
        chk("rst_sreq1", 16'(bus1.target_split_req), 16'h0);
        tick();

        // read of reset seed, ready low during the transaction
        rd(0, 16'h0013, 1, 8'hA3);
        chk("rd_busy0", 16'(bus0.target_ready), 16'h0);
        tick();
        chk("rd_busy1", 16'(bus0.target_ready), 16'h0);
        tick();
        tick();
        chk("rd_done_ready", 16'(bus0.target_ready), 16'h1);

        // same-cycle write then read back
        wr(0, 16'h0012, 8'h5C);
        tick();
        rd(0, 16'h0012, 1, 8'h5C);
        repeat (3) tick();

        // early data strobe, address three cycles later
        drv(0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h77);
        tick();
        idle(0);
        repeat (3) tick();
        drv(0, 1'b1, 16'h0011, 1'b1, 1'b0, 8'h0);
        sbq[0].push_back('{rd: 1'b0, d: 8'h0, c: cyc + 1});
        tick();
        idle(0);
        tick();
        chk("dout_hold", 16'(bus0.target_data_out), 16'h005C);
        rd(0, 16'h0011, 1, 8'h77);
        repeat (3) tick();

        // address first, data collected later
        drv(0, 1'b1, 16'h0014, 1'b1, 1'b0, 8'h0);
        tick();
        idle(0);
        tick();
        chk("collect_busy", 16'(bus0.target_ready), 16'h0);
        tick();
        drv(0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h3D);
        sbq[0].push_back('{rd: 1'b0, d: 8'h0, c: cyc + 1});
        tick();
        idle(0);
        tick();
        rd(0, 16'h0014, 1, 8'h3D);
        repeat (3) tick();

        // out-of-range reads on both sides of the window
        for (int i = 0; i < 3; i++) begin
            rd(0, oor[i], 0, 8'h0);
            chk("oor_ready", 16'(bus0.target_ready), 16'h1);
            chk("oor_valid", 16'(bus0.target_data_out_valid), 16'h0);
            tick();
        end

        // out-of-range address drops pending data; last address
        drv(0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h99);
        tick();
        drv(0, 1'b1, 16'h0034, 1'b1, 1'b0, 8'h0);
        tick();
        idle(0);
        tick();
        drv(0, 1'b1, 16'h001F, 1'b1, 1'b0, 8'h0);
        tick();
        idle(0);
        chk("pend_clr0", 16'(bus0.target_ready), 16'h0);
        tick();
        chk("pend_clr1", 16'(bus0.target_ready), 16'h0);
        drv(0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h42);
        sbq[0].push_back('{rd: 1'b0, d: 8'h0, c: cyc + 1});
        tick();
        idle(0);
        tick();
        rd(0, 16'h001F, 1, 8'h42);
        repeat (3) tick();
        rd(0, 16'h0010, 1, 8'hA0);
        repeat (3) tick();

        // split read with grant delayed four cycles
        drv(1, 1'b1, 16'h0015, 1'b0, 1'b0, 8'h0);
        spq.push_back(cyc + 1);
        tick();
        idle(1);
        chk("split_sreq_c0", 16'(bus1.target_split_req), 16'h0);
        chk("split_busy", 16'(bus1.target_ready), 16'h0);
        tick();
        chk("split_sreq_c1", 16'(bus1.target_split_req), 16'h0);
        tick();
        chk("split_sreq_c2", 16'(bus1.target_split_req), 16'h1);
        repeat (4) begin
            tick();
            chk("split_sreq_hold", 16'(bus1.target_split_req), 16'h1);
        end
        bus1.target_split_grant = 1'b1;
        sbq[1].push_back('{rd: 1'b1, d: 8'hA5, c: cyc + 1});
        tick();
        bus1.target_split_grant = 1'b0;
        chk("split_sreq_drop", 16'(bus1.target_split_req), 16'h0);
        repeat (2) tick();
        chk("split_done_ready", 16'(bus1.target_ready), 16'h1);

        // reset while waiting for the grant
        drv(1, 1'b1, 16'h0016, 1'b0, 1'b0, 8'h0);
        spq.push_back(cyc + 1);
        tick();
        idle(1);
        tick();
        tick();
        chk("resume_sreq", 16'(bus1.target_split_req), 16'h1);
        rst = 1'b1;
        #1;
        chk("arst_sreq", 16'(bus1.target_split_req), 16'h0);
        chk("arst_ready", 16'(bus1.target_ready), 16'h1);
        chk("arst_ack", 16'(bus1.target_ack), 16'h0);
        tick();
        rst = 1'b0;
        bus1.target_split_grant = 1'b1;
        repeat (4) tick();
        bus1.target_split_grant = 1'b0;
        chk("arst_idle", 16'(bus1.target_ready), 16'h1);

        // memory seed restored by reset
        rd(0, 16'h0012, 1, 8'hA2);
        repeat (3) tick();

        chk("sb0_empty", 16'(sbq[0].size()), 16'h0);
        chk("sb1_empty", 16'(sbq[1].size()), 16'h0);
        chk("split_q_empty", 16'(spq.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
